bpi_flash_read_fsm: RTL
=======================

Name: bpi_flash_read_fsm

Overview:
- Read-side engine of the BPI flash AXI slave: the counterpart of the write engine.
- Takes one decoded read burst from the address front-end and issues one memory-word read request per flash word to the flash PHY.
- Collects the returned flash words, packs them into AXI data beats and drives the AXI R channel with RLAST/RRESP.
- Sits between the AR decoder (s_axis_rq), the flash PHY read port (m_axis_rd / s_axis_rd) and the AXI slave R channel.

Parameters:
- C_AXI_WIDTH, 32, AXI data width in bits; integer multiple of C_MEM_WIDTH.
- C_MEM_WIDTH, 16, flash data bus width in bits.
- C_MEM_SIZE, 134217728, flash size in bytes.
- Derived, not overridable: AW = $clog2(8*C_MEM_SIZE/C_MEM_WIDTH); R = C_AXI_WIDTH/C_MEM_WIDTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  allows acceptance of new requests
- active  out  1  high from request acceptance until the final R handshake
- s_axis_rq_tdata  in  AW  start flash word address
- s_axis_rq_tuser  in  9  [8]=decode error, [7:0]=ARLEN (beats-1)
- s_axis_rq_tvalid  in  1  request valid
- s_axis_rq_tready  out  1  request ready
- m_axis_rd_tdest  out  AW  flash word address to read
- m_axis_rd_tvalid  out  1  read command valid
- m_axis_rd_tready  in  1  PHY accepts command
- s_axis_rd_tdata  in  C_MEM_WIDTH  returned flash word
- s_axis_rd_tvalid  in  1  returned word valid
- s_axis_rd_tready  out  1  ready for returned word
- s_axi_rdata  out  C_AXI_WIDTH  read data beat
- s_axi_rresp  out  2  OKAY=00, SLVERR=10
- s_axi_rlast  out  1  last beat of burst
- s_axi_rvalid  out  1  beat valid
- s_axi_rready  in  1  master ready

Behaviour:
- Reset: every output 0; state ST_IDLE; internal address, beat counter, slice index, error and overflow flags cleared.
- All outputs are registered. A handshake completes on a clock edge with valid&ready both high.
- ST_IDLE:
  - s_axis_rq_tready <= enable; active <= 0.
  - On handshake: latch op_addr=tdata, op_error=tuser[8], beats_left=tuser[7:0]; slice index k=0; overflow flag cleared; tready <= 0; active <= 1; go to ST_REQ_MEM.
- ST_REQ_MEM:
  - Compute {carry, addr} = op_addr + k (AW+1 bits). carry=1 sets the sticky ovf flag.
  - If op_error or ovf: do not issue a command; slice k <= 0; mark the beat SLVERR; advance k.
  - Otherwise assert m_axis_rd_tvalid with tdest=addr, hold until the handshake, then go to ST_WAIT_DATA.
- ST_WAIT_DATA:
  - s_axis_rd_tready=1.
  - On handshake: slice k (bits [k*C_MEM_WIDTH +: C_MEM_WIDTH], little-endian) <= tdata; tready <= 0.
  - If k==R-1 go to ST_SEND_BEAT, else k++ and return to ST_REQ_MEM.
  - Exactly one command is outstanding at a time.
- ST_SEND_BEAT:
  - s_axi_rvalid=1 with rdata stable; rresp=10 if op_error or any slice in the beat was skipped, else 00; rlast=(beats_left==0).
  - On handshake: rvalid <= 0; op_addr += R (the carry sets ovf); k=0.
  - If rlast go to ST_IDLE with active <= 0, else beats_left-- and go to ST_REQ_MEM.
- Error burst (op_error=1): no flash commands are issued; ARLEN+1 beats of zero data with SLVERR are still returned with a correct rlast.
- Wrap-around: addresses never wrap to 0. The first out-of-range word and all later words of the burst read as 0 with SLVERR. Earlier in-range words of the same beat keep their data but the whole beat is SLVERR.
- When C_AXI_WIDTH==C_MEM_WIDTH (R=1), k is always 0 and the slice logic degenerates to a single word.
- enable deasserted mid-burst does not abort the burst; it only blocks the next acceptance.
- Reset mid-burst returns to ST_IDLE immediately with all valids low. No partial beat or command is emitted after reset.
- Minimum latency with ready PHY and master, R=2, one-cycle PHY:
  - rq handshake → first m_axis_rd_tvalid: 1 cycle.
  - Per word: command handshake + data handshake.
  - Beat valid: 1 cycle after the last slice's data handshake.
- Backpressure: rdata and rresp are held stable while rvalid=1 and rready=0.

Test Plan:
- Single beat, R=2: rq addr=0x100, len=0, no error; PHY returns 0xAAAA then 0x5555 → commands at tdest 0x100 then 0x101; one beat rdata=0x5555AAAA, rresp=00, rlast=1; active falls after the handshake.
- 4-beat burst from addr=0x20 with random rready stalls → 8 commands at 0x20..0x27 in order; 4 beats with rlast only on the 4th; data stable during stalls.
- Error request (tuser[8]=1, len=3) → zero m_axis_rd_tvalid pulses; 4 beats rdata=0, rresp=10, rlast on the 4th.
- Wrap: start at last word (2^AW-1), len=1 → one command at 2^AW-1; beat 0 = {0, word}, SLVERR; beat 1 = 0, SLVERR; no command at address 0.
- PHY stalls (tready low 5 cycles, data returned 7 cycles late) → only one command outstanding at a time; s_axis_rq_tready stays 0 until the burst ends; correct packing.
- Reset asserted during ST_WAIT_DATA of beat 2 → next cycle all outputs 0 and state idle; a fresh request after reset completes normally.

Source files
------------

// File: rtl/bpi_flash_read_fsm.sv
// Read engine of the BPI flash AXI slave: issues one flash read per word of a
// decoded burst and packs the returned words little-endian into AXI R beats.
module bpi_flash_read_fsm #(
  parameter int     C_AXI_WIDTH = 32,
  parameter int     C_MEM_WIDTH = 16,
  parameter longint C_MEM_SIZE  = 134217728,
  localparam int    AW = $clog2(8 * C_MEM_SIZE / C_MEM_WIDTH),
  localparam int    R  = C_AXI_WIDTH / C_MEM_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  output logic                   active,
  input  logic [AW-1:0]          s_axis_rq_tdata,
  input  logic [8:0]             s_axis_rq_tuser,
  input  logic                   s_axis_rq_tvalid,
  output logic                   s_axis_rq_tready,
  output logic [AW-1:0]          m_axis_rd_tdest,
  output logic                   m_axis_rd_tvalid,
  input  logic                   m_axis_rd_tready,
  input  logic [C_MEM_WIDTH-1:0] s_axis_rd_tdata,
  input  logic                   s_axis_rd_tvalid,
  output logic                   s_axis_rd_tready,
  output logic [C_AXI_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]             s_axi_rresp,
  output logic                   s_axi_rlast,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready
);

  localparam int KW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ_MEM, ST_WAIT_DATA, ST_SEND_BEAT} state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          op_addr_q, op_addr_d;
  logic                   op_error_q, op_error_d;
  logic                   ovf_q, ovf_d;
  logic                   beat_err_q, beat_err_d;
  logic [7:0]             beats_left_q, beats_left_d;
  logic [KW-1:0]          k_q, k_d;
  logic                   active_q, active_d;
  logic                   rq_tready_q, rq_tready_d;
  logic [AW-1:0]          rd_tdest_q, rd_tdest_d;
  logic                   rd_tvalid_q, rd_tvalid_d;
  logic                   rd_tready_q, rd_tready_d;
  logic [C_AXI_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]             rresp_q, rresp_d;
  logic                   rlast_q, rlast_d;
  logic                   rvalid_q, rvalid_d;

  logic [AW:0]            word_sum, beat_sum;
  logic                   skip, last_k;
  logic                   word_done, slice_we;
  logic [C_MEM_WIDTH-1:0] slice_val;

  assign word_sum = {1'b0, op_addr_q} + {{(AW + 1 - KW){1'b0}}, k_q};
  assign beat_sum = {1'b0, op_addr_q} + (AW + 1)'(R);
  // A word is skipped for decode errors or once the burst has run off the top of flash.
  assign skip     = op_error_q | ovf_q | word_sum[AW];
  assign last_k   = (k_q == KW'(R - 1));

  always_comb begin
    state_d      = state_q;
    op_addr_d    = op_addr_q;
    op_error_d   = op_error_q;
    ovf_d        = ovf_q;
    beat_err_d   = beat_err_q;
    beats_left_d = beats_left_q;
    k_d          = k_q;
    active_d     = active_q;
    rq_tready_d  = rq_tready_q;
    rd_tdest_d   = rd_tdest_q;
    rd_tvalid_d  = rd_tvalid_q;
    rd_tready_d  = rd_tready_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    rlast_d      = rlast_q;
    rvalid_d     = rvalid_q;
    word_done    = 1'b0;
    slice_we     = 1'b0;
    slice_val    = '0;

    case (state_q)
      ST_IDLE: begin
        rq_tready_d = enable;
        active_d    = 1'b0;
        if (rq_tready_q && s_axis_rq_tvalid) begin
          op_addr_d    = s_axis_rq_tdata;
          op_error_d   = s_axis_rq_tuser[8];
          beats_left_d = s_axis_rq_tuser[7:0];
          k_d          = '0;
          ovf_d        = 1'b0;
          beat_err_d   = 1'b0;
          rq_tready_d  = 1'b0;
          active_d     = 1'b1;
          state_d      = ST_REQ_MEM;
          // First word of a good burst can never carry, so issue it straight away.
          if (!s_axis_rq_tuser[8]) begin
            rd_tvalid_d = 1'b1;
            rd_tdest_d  = s_axis_rq_tdata;
          end
        end
      end
      ST_REQ_MEM: begin
        if (rd_tvalid_q) begin
          if (m_axis_rd_tready) begin
            rd_tvalid_d = 1'b0;
            rd_tready_d = 1'b1;
            state_d     = ST_WAIT_DATA;
          end
        end else begin
          if (word_sum[AW]) ovf_d = 1'b1;
          if (skip) begin
            slice_we   = 1'b1;
            beat_err_d = 1'b1;
            word_done  = 1'b1;
          end else begin
            rd_tvalid_d = 1'b1;
            rd_tdest_d  = word_sum[AW-1:0];
          end
        end
      end
      ST_WAIT_DATA: begin
        if (rd_tready_q && s_axis_rd_tvalid) begin
          slice_we    = 1'b1;
          slice_val   = s_axis_rd_tdata;
          rd_tready_d = 1'b0;
          word_done   = 1'b1;
        end
      end
      ST_SEND_BEAT: begin
        if (s_axi_rready) begin
          rvalid_d   = 1'b0;
          rlast_d    = 1'b0;
          op_addr_d  = beat_sum[AW-1:0];
          if (beat_sum[AW]) ovf_d = 1'b1;
          k_d        = '0;
          beat_err_d = 1'b0;
          if (rlast_q) begin
            active_d = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            beats_left_d = beats_left_q - 8'd1;
            state_d      = ST_REQ_MEM;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (word_done) begin
      if (last_k) begin
        rvalid_d = 1'b1;
        rresp_d  = (op_error_q || beat_err_d) ? 2'b10 : 2'b00;
        rlast_d  = (beats_left_q == 8'd0);
        state_d  = ST_SEND_BEAT;
      end else begin
        k_d     = k_q + KW'(1);
        state_d = ST_REQ_MEM;
      end
    end

    for (int i = 0; i < R; i++) begin
      if (slice_we && (k_q == KW'(i))) rdata_d[i*C_MEM_WIDTH +: C_MEM_WIDTH] = slice_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_addr_q    <= '0;
      op_error_q   <= 1'b0;
      ovf_q        <= 1'b0;
      beat_err_q   <= 1'b0;
      beats_left_q <= '0;
      k_q          <= '0;
      active_q     <= 1'b0;
      rq_tready_q  <= 1'b0;
      rd_tdest_q   <= '0;
      rd_tvalid_q  <= 1'b0;
      rd_tready_q  <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= 2'b00;
      rlast_q      <= 1'b0;
      rvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_addr_q    <= op_addr_d;
      op_error_q   <= op_error_d;
      ovf_q        <= ovf_d;
      beat_err_q   <= beat_err_d;
      beats_left_q <= beats_left_d;
      k_q          <= k_d;
      active_q     <= active_d;
      rq_tready_q  <= rq_tready_d;
      rd_tdest_q   <= rd_tdest_d;
      rd_tvalid_q  <= rd_tvalid_d;
      rd_tready_q  <= rd_tready_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      rlast_q      <= rlast_d;
      rvalid_q     <= rvalid_d;
    end
  end

  assign active           = active_q;
  assign s_axis_rq_tready = rq_tready_q;
  assign m_axis_rd_tdest  = rd_tdest_q;
  assign m_axis_rd_tvalid = rd_tvalid_q;
  assign s_axis_rd_tready = rd_tready_q;
  assign s_axi_rdata      = rdata_q;
  assign s_axi_rresp      = rresp_q;
  assign s_axi_rlast      = rlast_q;
  assign s_axi_rvalid     = rvalid_q;

endmodule
